// File: rtl/tc_seq_pkg.sv
// Shared types, default constants and the saturating-increment helper for the
// testcase sequencer.
package tc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LAUNCH,
    ST_WAIT,
    ST_RECORD,
    ST_FINISH
  } tc_seq_state_t;

  localparam int TC_SEQ_TIMEOUT_CYCLES = 1000;
  localparam int TC_SEQ_CNT_W          = 16;

  // Counters of up to 32 bits; the caller passes its own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/tc_seq_watchdog.sv
// Per-test watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES-1.
module tc_seq_watchdog
  import tc_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TC_SEQ_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (enable_i && (timer_q != LIMIT)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout_o = enable_i && (timer_q == LIMIT);

endmodule

// File: rtl/tc_sequencer.sv
// Runs each enabled testcase in turn against a shared engine, tallying results.
// Define TC_SEQ_STOP_ON_FAIL_EN to end the suite at the first fail or timeout.
module tc_sequencer
  import tc_seq_pkg::*;
#(
  parameter int NUM_TESTS      = 4,
  parameter int ID_W           = 8,
  parameter int TIMEOUT_CYCLES = TC_SEQ_TIMEOUT_CYCLES,
  parameter int CNT_W          = TC_SEQ_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_TESTS-1:0] enable_mask_i,
  output logic                 tc_start_o,
  output logic [ID_W-1:0]      tc_id_o,
  input  logic                 tc_done_i,
  input  logic                 tc_pass_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 all_pass_o,
  output logic [CNT_W-1:0]     pass_cnt_o,
  output logic [CNT_W-1:0]     fail_cnt_o,
  output logic [CNT_W-1:0]     timeout_cnt_o
);

  localparam int          IDX_W   = $clog2(NUM_TESTS + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  tc_seq_state_t          state_q, state_d;
  logic [NUM_TESTS-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ID_W-1:0]        tc_id_q, tc_id_d;
  logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]       timeout_cnt_q, timeout_cnt_d;
  logic                   all_pass_q, all_pass_d;
  logic                   verdict_q, verdict_d;
  logic                   timed_out_q, timed_out_d;
  logic                   rec_fail;
  logic                   suite_pass;
  logic                   wd_timeout;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [IDX_W:0] find_next(input logic [NUM_TESTS-1:0] mask,
                                                input logic [IDX_W-1:0]     from);
    logic [IDX_W:0] result;
    result = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        result = {1'b1, IDX_W'(i)};
      end
    end
    return result;
  endfunction

  assign {sel_found, sel_idx} = find_next(mask_q, idx_q);
  assign suite_pass = (fail_cnt_q == '0) && (pass_cnt_q != '0);

  tc_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == ST_LAUNCH),
    .enable_i (state_q == ST_WAIT),
    .timeout_o(wd_timeout)
  );

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    tc_id_d       = tc_id_q;
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    all_pass_d    = all_pass_q;
    verdict_d     = verdict_q;
    timed_out_d   = timed_out_q;
    rec_fail      = timed_out_q || !verdict_q;
    tc_start_o    = 1'b0;
    done_o        = 1'b0;
    all_pass_o    = all_pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d        = enable_mask_i;
          idx_d         = '0;
          pass_cnt_d    = '0;
          fail_cnt_d    = '0;
          timeout_cnt_d = '0;
          all_pass_d    = 1'b0;
          state_d       = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          tc_id_d = ID_W'(sel_idx);
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_LAUNCH: begin
        tc_start_o = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the watchdog's final cycle still counts as a verdict.
        if (tc_done_i) begin
          verdict_d   = tc_pass_i;
          timed_out_d = 1'b0;
          state_d     = ST_RECORD;
        end else if (wd_timeout) begin
          verdict_d   = 1'b0;
          timed_out_d = 1'b1;
          state_d     = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (timed_out_q) begin
          fail_cnt_d    = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_MAX));
          timeout_cnt_d = CNT_W'(sat_inc(32'(timeout_cnt_q), CNT_MAX));
        end else if (verdict_q) begin
          pass_cnt_d    = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_MAX));
        end else begin
          fail_cnt_d    = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_MAX));
        end
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_SELECT;
`ifdef TC_SEQ_STOP_ON_FAIL_EN
        if (rec_fail) begin
          state_d = ST_FINISH;
        end
`endif
      end
      ST_FINISH: begin
        done_o     = 1'b1;
        all_pass_o = suite_pass;
        all_pass_d = suite_pass;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort abandons the run without touching results or pulsing done.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      pass_cnt_d    = pass_cnt_q;
      fail_cnt_d    = fail_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      all_pass_d    = all_pass_q;
      all_pass_o    = all_pass_q;
      done_o        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      tc_id_q       <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      all_pass_q    <= 1'b0;
      verdict_q     <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      tc_id_q       <= tc_id_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      all_pass_q    <= all_pass_d;
      verdict_q     <= verdict_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign tc_id_o       = tc_id_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign pass_cnt_o    = pass_cnt_q;
  assign fail_cnt_o    = fail_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_tc_sequencer.sv
// Bench for tc_sequencer: table vectors, hand-written abort/reset sequences and
// random suites checked against a cycle-accurate reference model of the suite.
module tb_tc_sequencer;

  localparam int T = 10;

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][7:0] lat;
    logic [3:0]      pas;
    logic [15:0]     ep;
    logic [15:0]     ef;
    logic [15:0]     eto;
    logic            eall;
    logic [3:0]      elaunch;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [3:0]  enable_mask_i;
  logic        tc_start_o;
  logic [7:0]  tc_id_o;
  logic        tc_done_i;
  logic        tc_pass_i;
  logic        busy_o;
  logic        done_o;
  logic        all_pass_o;
  logic [15:0] pass_cnt_o;
  logic [15:0] fail_cnt_o;
  logic [15:0] timeout_cnt_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [3:0][7:0] resp_lat;
  logic [3:0]      resp_pass;
  int eng_cnt;
  logic eng_pass;
  int run_start;
  int act_ids[$];
  int act_lcyc[$];
  int exp_ids[$];
  int exp_lcyc[$];
  int exp_done, exp_pass, exp_fail, exp_to;
  logic exp_all;
  int got_done_cyc, got_pass, got_fail, got_to;
  logic got_all, got_seen;
  vec_t tbl[8];

  tc_sequencer #(
    .NUM_TESTS(4),
    .ID_W(8),
    .TIMEOUT_CYCLES(T),
    .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .enable_mask_i(enable_mask_i),
    .tc_start_o   (tc_start_o),
    .tc_id_o      (tc_id_o),
    .tc_done_i    (tc_done_i),
    .tc_pass_i    (tc_pass_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .all_pass_o   (all_pass_o),
    .pass_cnt_o   (pass_cnt_o),
    .fail_cnt_o   (fail_cnt_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [3:0][7:0] mkLat(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Engine behaviour: answers 'lat' cycles after its launch pulse (0 = never).
  task automatic engineStep();
    tc_done_i = 1'b0;
    tc_pass_i = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        tc_done_i = 1'b1;
        tc_pass_i = eng_pass;
      end
    end
    if (tc_start_o) begin
      act_ids.push_back(int'(tc_id_o));
      act_lcyc.push_back(cyc - run_start);
      eng_cnt  = int'(resp_lat[tc_id_o[1:0]]);
      eng_pass = resp_pass[tc_id_o[1:0]];
    end
  endtask

  // Suite timing from the rules: first launch two cycles after start; a test
  // waiting w cycles costs w+3 cycles to the next launch or to FINISH.
  task automatic modelRun(input logic [3:0] mask);
    int c, w, lat;
    bit bad, stopped;
    exp_ids.delete();
    exp_lcyc.delete();
    c = 2; exp_pass = 0; exp_fail = 0; exp_to = 0; stopped = 0; exp_done = 0;
    for (int id = 0; id < 4; id++) begin
      if (mask[id] && !stopped) begin
        exp_ids.push_back(id);
        exp_lcyc.push_back(c);
        lat = int'(resp_lat[id]);
        bad = 0;
        if (lat == 0 || lat > T) begin
          w = T; exp_to++; exp_fail++; bad = 1;
        end else begin
          w = lat;
          if (resp_pass[id]) exp_pass++;
          else begin exp_fail++; bad = 1; end
        end
`ifdef TC_SEQ_STOP_ON_FAIL_EN
        if (bad) begin
          exp_done = c + w + 2;
          stopped = 1;
        end
`endif
        if (!stopped) c = c + w + 3;
      end
    end
    if (!stopped) exp_done = c;
    exp_all = (exp_fail == 0) && (exp_pass != 0);
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input string tag);
    act_ids.delete();
    act_lcyc.delete();
    eng_cnt = 0;
    got_seen = 0;
    @(negedge clk);
    enable_mask_i = mask;
    start_i = 1'b1;
    run_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
    enable_mask_i = 4'($urandom);
    checkOutput($sformatf("%s busy_at_select", tag), int'(busy_o), 1);
    checkOutput($sformatf("%s cnt_cleared", tag), int'(pass_cnt_o) + int'(fail_cnt_o) + int'(timeout_cnt_o), 0);
    checkOutput($sformatf("%s all_pass_cleared", tag), int'(all_pass_o), 0);
    for (int k = 0; k < 300; k++) begin
      engineStep();
      if (done_o) begin
        got_seen = 1;
        got_done_cyc = cyc - run_start;
        got_all = all_pass_o;
        got_pass = int'(pass_cnt_o);
        got_fail = int'(fail_cnt_o);
        got_to = int'(timeout_cnt_o);
        break;
      end
      @(negedge clk);
    end
    tc_done_i = 1'b0;
    tc_pass_i = 1'b0;
    checkOutput($sformatf("%s done_seen", tag), int'(got_seen), 1);
    @(negedge clk);
    checkOutput($sformatf("%s done_single_pulse", tag), int'(done_o), 0);
    checkOutput($sformatf("%s busy_after_finish", tag), int'(busy_o), 0);
    checkOutput($sformatf("%s all_pass_held", tag), int'(all_pass_o), int'(got_all));
  endtask

  task automatic checkTiming(input string tag);
    int n;
    checkOutput($sformatf("%s n_launches", tag), act_ids.size(), exp_ids.size());
    n = (act_ids.size() < exp_ids.size()) ? act_ids.size() : exp_ids.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s launch%0d_id", tag, i), act_ids[i], exp_ids[i]);
      checkOutput($sformatf("%s launch%0d_cycle", tag, i), act_lcyc[i], exp_lcyc[i]);
    end
    checkOutput($sformatf("%s done_cycle", tag), got_done_cyc, exp_done);
  endtask

  task automatic checkCounts(input string tag, input int ep, input int ef, input int eto,
                             input logic eall, input logic [3:0] elaunch);
    logic [3:0] lm;
    lm = '0;
    foreach (act_ids[i]) lm[act_ids[i][1:0]] = 1'b1;
    checkOutput($sformatf("%s launched_mask", tag), int'(lm), int'(elaunch));
    checkOutput($sformatf("%s pass_cnt", tag), got_pass, ep);
    checkOutput($sformatf("%s fail_cnt", tag), got_fail, ef);
    checkOutput($sformatf("%s timeout_cnt", tag), got_to, eto);
    checkOutput($sformatf("%s all_pass", tag), int'(got_all), int'(eall));
  endtask

  initial begin
    int hits, k;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; enable_mask_i = '0;
    tc_done_i = 1'b0; tc_pass_i = 1'b0; eng_cnt = 0; eng_pass = 1'b0;
    resp_lat = '0; resp_pass = '0;

    tbl[0] = '{mask:4'b1111, lat:mkLat(5,5,5,5), pas:4'b1111, ep:4, ef:0, eto:0, eall:1, elaunch:4'b1111};
    tbl[1] = '{mask:4'b1010, lat:mkLat(5,5,5,5), pas:4'b0111, ep:1, ef:1, eto:0, eall:0, elaunch:4'b1010};
`ifdef TC_SEQ_STOP_ON_FAIL_EN
    tbl[2] = '{mask:4'b0011, lat:mkLat(0,5,5,5), pas:4'b1111, ep:0, ef:1, eto:1, eall:0, elaunch:4'b0001};
    tbl[6] = '{mask:4'b1111, lat:mkLat(3,3,3,3), pas:4'b1110, ep:0, ef:1, eto:0, eall:0, elaunch:4'b0001};
`else
    tbl[2] = '{mask:4'b0011, lat:mkLat(0,5,5,5), pas:4'b1111, ep:1, ef:1, eto:1, eall:0, elaunch:4'b0011};
    tbl[6] = '{mask:4'b1111, lat:mkLat(3,3,3,3), pas:4'b1110, ep:3, ef:1, eto:0, eall:0, elaunch:4'b1111};
`endif
    tbl[3] = '{mask:4'b0011, lat:mkLat(10,5,5,5), pas:4'b1111, ep:2, ef:0, eto:0, eall:1, elaunch:4'b0011};
    tbl[4] = '{mask:4'b0000, lat:mkLat(5,5,5,5), pas:4'b1111, ep:0, ef:0, eto:0, eall:0, elaunch:4'b0000};
    tbl[5] = '{mask:4'b0001, lat:mkLat(11,5,5,5), pas:4'b1111, ep:0, ef:1, eto:1, eall:0, elaunch:4'b0001};
    tbl[7] = '{mask:4'b1000, lat:mkLat(1,1,1,1), pas:4'b1111, ep:1, ef:0, eto:0, eall:1, elaunch:4'b1000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset tc_start", int'(tc_start_o), 0);
    checkOutput("reset tc_id", int'(tc_id_o), 0);
    checkOutput("reset busy", int'(busy_o), 0);
    checkOutput("reset done", int'(done_o), 0);
    checkOutput("reset all_pass", int'(all_pass_o), 0);
    checkOutput("reset counters", int'(pass_cnt_o) + int'(fail_cnt_o) + int'(timeout_cnt_o), 0);

    for (int v = 0; v < 8; v++) begin
      resp_lat = tbl[v].lat;
      resp_pass = tbl[v].pas;
      modelRun(tbl[v].mask);
      applyStimulus(tbl[v].mask, $sformatf("tbl%0d", v));
      checkTiming($sformatf("tbl%0d", v));
      checkCounts($sformatf("tbl%0d", v), int'(tbl[v].ep), int'(tbl[v].ef), int'(tbl[v].eto),
                  tbl[v].eall, tbl[v].elaunch);
    end

    // Abort during WAIT of ID 1, with a simultaneous done that must lose.
    resp_lat = mkLat(5,5,5,5);
    resp_pass = 4'b1111;
    act_ids.delete(); act_lcyc.delete(); eng_cnt = 0;
    @(negedge clk);
    enable_mask_i = 4'b0011; start_i = 1'b1; run_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
    for (k = 0; k < 100 && act_ids.size() < 2; k++) begin
      engineStep();
      if (act_ids.size() < 2) @(negedge clk);
    end
    checkOutput("abort reached_id1", act_ids.size(), 2);
    @(negedge clk);
    abort_i = 1'b1; tc_done_i = 1'b1; tc_pass_i = 1'b1;
    checkOutput("abort no_done_in_wait", int'(done_o), 0);
    @(negedge clk);
    abort_i = 1'b0; tc_done_i = 1'b0; tc_pass_i = 1'b0; eng_cnt = 0;
    checkOutput("abort busy", int'(busy_o), 0);
    checkOutput("abort pass_held", int'(pass_cnt_o), 1);
    checkOutput("abort fail_held", int'(fail_cnt_o), 0);
    hits = 0;
    repeat (6) begin
      if (done_o || tc_start_o) hits++;
      @(negedge clk);
    end
    checkOutput("abort quiet_after", hits, 0);
    resp_lat = mkLat(4,5,5,5);
    modelRun(4'b0001);
    applyStimulus(4'b0001, "post_abort");
    checkTiming("post_abort");
    checkCounts("post_abort", exp_pass, exp_fail, exp_to, exp_all, 4'b0001);

    // Spurious engine completions while idle are ignored.
    tc_done_i = 1'b1; tc_pass_i = 1'b1;
    repeat (3) @(negedge clk);
    tc_done_i = 1'b0; tc_pass_i = 1'b0;
    checkOutput("idle_done pass_cnt", int'(pass_cnt_o), 1);
    checkOutput("idle_done busy", int'(busy_o), 0);

    // Reset asserted while ID 2 waits on a silent engine.
    resp_lat = mkLat(5,2,0,5);
    resp_pass = 4'b1111;
    act_ids.delete(); act_lcyc.delete(); eng_cnt = 0;
    @(negedge clk);
    enable_mask_i = 4'b0110; start_i = 1'b1; run_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
    for (k = 0; k < 100 && act_ids.size() < 2; k++) begin
      engineStep();
      if (act_ids.size() < 2) @(negedge clk);
    end
    checkOutput("rst reached_id2", act_ids.size(), 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst tc_id", int'(tc_id_o), 0);
    checkOutput("rst pass_cnt", int'(pass_cnt_o), 0);
    checkOutput("rst busy", int'(busy_o), 0);
    checkOutput("rst done", int'(done_o), 0);
    checkOutput("rst tc_start", int'(tc_start_o), 0);
    resp_lat = mkLat(5,5,5,5);
    modelRun(4'b0001);
    applyStimulus(4'b0001, "post_rst");
    checkTiming("post_rst");
    checkCounts("post_rst", 1, 0, 0, 1'b1, 4'b0001);

    for (int r = 0; r < 20; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(0, 15));
      for (int id = 0; id < 4; id++) begin
        resp_lat[id] = 8'($urandom_range(0, 13));
        resp_pass[id] = 1'($urandom_range(0, 1));
      end
      modelRun(m);
      applyStimulus(m, $sformatf("rnd%0d", r));
      checkTiming($sformatf("rnd%0d", r));
      begin
        logic [3:0] el;
        el = '0;
        foreach (exp_ids[i]) el[exp_ids[i][1:0]] = 1'b1;
        checkCounts($sformatf("rnd%0d", r), exp_pass, exp_fail, exp_to, exp_all, el);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
